x_mac_ctrl: RTL
===============

# x_mac_ctrl

Sequencing controller for the 4-row X operand buffer and its MAC datapath. It loads 32 X bytes from the input stream into the buffer, then runs N_COL output columns. Each column takes 8 multiply-accumulate steps against a synchronous coefficient ROM, rotating the X buffer once per step, and ends with one result write. It sits between the host start/valid interface and the X buffer, coefficient ROM, MAC array and result RAM.

## Interface
- N_COL, 4: output columns per run (1..4)
- K, 8: MAC steps per column; fixed by the 8-byte X buffer depth
- ROM_AW, 5: coefficient ROM address width; must satisfy 2^ROM_AW >= N_COL*K

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request, sampled in IDLE only
- valid_input  in  1  host byte valid; byte itself goes straight to the buffer
- xload_done  in  1  X buffer load-complete flag, used for the consistency check
- input_load_en  out  1  buffer load enable; also host ready
- x_shift  out  1  rotate all X buffer rows by one byte
- rom_addr  out  ROM_AW  coefficient address, col*K+step
- mac_en  out  1  MAC accumulate strobe
- mac_first  out  1  with mac_en: load the product instead of accumulating
- ram_we  out  1  result write strobe
- ram_addr  out  2  result column index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle end-of-run pulse
- err  out  1  sticky load-count mismatch; cleared only by rst

## Operation
- States: IDLE, LOAD, ISSUE, DRAIN, WRITE, DONE.
- IDLE, start=1: go to LOAD. start is ignored in every other state.
- LOAD:
  - input_load_en=1.
  - 5-bit load_cnt increments on each cycle with valid_input=1.
  - Cycles without valid stall the count. No timeout.
  - When valid_input=1 and load_cnt=31: go to ISSUE, load_cnt wraps to 0.
- Load check: on any LOAD cycle with load_cnt=31 and valid_input=1, if xload_done=0 then err is set.
- ISSUE:
  - step counter 0..K-1; each cycle drives rom_addr=col*K+step.
  - Registered issue flag, one cycle later: mac_en=1 and x_shift=1; mac_first=1 for step 0 only.
  - After step K-1: go to DRAIN.
- DRAIN: one cycle. The pipelined mac_en/x_shift for step K-1 fires here; no new address is issued.
- WRITE: one cycle. ram_we=1, ram_addr=col.
  - If col=N_COL-1: go to DONE.
  - Otherwise col increments and the FSM goes to ISSUE with step=0.
- DONE: done=1 for one cycle, then IDLE. col and step are cleared.
- Buffer alignment: exactly K shifts per column, so X rows return to original alignment before the next column. K*N_COL shifts per run.
- rom_addr holds its last value outside ISSUE. Width is truncated to ROM_AW.
- The controller does not clear the X buffer. The system ties the buffer reset to the same reset event.

## Timing
- Reset values: state IDLE; all counters 0. input_load_en, x_shift, mac_en, mac_first, ram_we, busy, done, err = 0; rom_addr = 0; ram_addr = 0.
- rst mid-run: the next cycle is IDLE with all reset values; any in-flight mac_en is dropped.
- Run numbering: start sampled in cycle 0; LOAD occupies cycle 1 onward.
- With back-to-back valid:
  - last byte in cycle 32
  - column c: ISSUE cycles 33+10c .. 40+10c, DRAIN 41+10c, WRITE 42+10c
  - mac_en cycles 34+10c .. 41+10c
  - N_COL=4: done in cycle 73, IDLE in cycle 74.
- Per-column cost: K+2 cycles. Total run: 32 + N_COL*(K+2) + 1 cycles after LOAD entry, plus stall cycles.
- mac_en and x_shift are always identical. mac_first never asserts without mac_en.
- ROM read latency is exactly 1 cycle: the address in cycle t is matched to mac_en in cycle t+1.

## Test plan
- Back-to-back load, N_COL=4:
  - 32 valid bytes from cycle 1 -> input_load_en falls in cycle 33.
  - rom_addr 0..7 in cycles 33..40; mac_en in cycles 34..41; mac_first only in cycle 34.
  - ram_we in cycles 42, 52, 62, 72 with ram_addr 0..3; done in cycle 73; 32 x_shift pulses total.
- Gapped load: valid_input low on every odd cycle -> 32 bytes accepted over 63 cycles; ISSUE entered the cycle after the 32nd accepted byte; load_cnt never double counts.
- start held high during the whole run -> a single run only. start=1 in cycle 74 (IDLE) -> a second run begins, with LOAD in cycle 75.
- rst=1 in cycle 50 (column 1 ISSUE) -> cycle 51: busy=0, mac_en=0, rom_addr=0. A new start then gives a full run with the same timing as the first test.
- xload_done tied 0 -> err=1 in the cycle after the 32nd byte; the run still completes; err stays 1 until rst.
- N_COL=1 build -> single column; ram_we in cycle 42 with ram_addr 0; done in cycle 43.

Source files
------------

// File: rtl/x_mac_ctrl_if.sv
// rtl/x_mac_ctrl_if.sv - host, X buffer, ROM, MAC and result RAM signals of the MAC controller
interface x_mac_ctrl_if #(
   parameter int ROM_AW = 5
);
   logic              start;
   logic              valid_input;
   logic              xload_done;
   logic              input_load_en;
   logic              x_shift;
   logic [ROM_AW-1:0] rom_addr;
   logic              mac_en;
   logic              mac_first;
   logic              ram_we;
   logic [1:0]        ram_addr;
   logic              busy;
   logic              done;
   logic              err;

   // controller side
   modport master (
      input  start, valid_input, xload_done,
      output input_load_en, x_shift, rom_addr, mac_en, mac_first,
             ram_we, ram_addr, busy, done, err
   );

   // host / datapath side
   modport slave (
      output start, valid_input, xload_done,
      input  input_load_en, x_shift, rom_addr, mac_en, mac_first,
             ram_we, ram_addr, busy, done, err
   );
endinterface

// File: rtl/x_mac_ctrl.sv
// rtl/x_mac_ctrl.sv - X buffer load and MAC column sequencing controller
module x_mac_ctrl #(
   parameter int N_COL  = 4,
   parameter int K      = 8,
   parameter int ROM_AW = 5
) (
   input  logic         clk,
   input  logic         rst,
   x_mac_ctrl_if.master bus
);
   localparam int STEP_W = $clog2(K);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        load_cnt;
   logic [STEP_W-1:0] step;
   logic [1:0]        col;
   logic [ROM_AW-1:0] rom_hold;
   logic [ROM_AW-1:0] rom_cur;
   logic              issue_q;
   logic              first_q;
   logic              err_q;
   logic              load_last;
   logic              step_last;
   logic              col_last;
   logic              load_en;
   logic              we;
   logic              done_p;

   assign load_last = (state == LOAD) && bus.valid_input && (load_cnt == 5'd31);
   assign step_last = (step == STEP_W'(K - 1));
   assign col_last  = (col == 2'(N_COL - 1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state, strobes and ROM address (address holds its last value outside ISSUE)
   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      we        = 1'b0;
      done_p    = 1'b0;
      rom_cur   = rom_hold;
      case (state)
         IDLE:  if (bus.start) state_nxt = LOAD;
         LOAD: begin
            load_en = 1'b1;
            if (load_last) state_nxt = ISSUE;
         end
         ISSUE: begin
            rom_cur = ROM_AW'(int'(col) * K + int'(step));
            if (step_last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = WRITE;
         WRITE: begin
            we        = 1'b1;
            state_nxt = col_last ? DONE : ISSUE;
         end
         DONE: begin
            done_p    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // counters, held address, one-cycle issue pipeline matching ROM latency, sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         load_cnt <= '0;
         step     <= '0;
         col      <= '0;
         rom_hold <= '0;
         issue_q  <= 1'b0;
         first_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rom_hold <= rom_cur;
         issue_q  <= (state == ISSUE);
         first_q  <= (state == ISSUE) && (step == '0);
         if (state == LOAD && bus.valid_input) load_cnt <= load_cnt + 5'd1;
         if (load_last && !bus.xload_done) err_q <= 1'b1;
         if (state == ISSUE) step <= step_last ? '0 : step + STEP_W'(1);
         if (state == WRITE && !col_last) col <= col + 2'd1;
         if (state == DONE) begin
            col  <= '0;
            step <= '0;
         end
      end
   end

   assign bus.input_load_en = load_en;
   assign bus.x_shift       = issue_q;
   assign bus.mac_en        = issue_q;
   assign bus.mac_first     = first_q;
   assign bus.rom_addr      = rom_cur;
   assign bus.ram_we        = we;
   assign bus.ram_addr      = col;
   assign bus.busy          = (state != IDLE);
   assign bus.done          = done_p;
   assign bus.err           = err_q;
endmodule
